// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, FSM encoding, MMIO decode bit and bus payload
// type for the data-side memory controller.
package dmem_pkg;

  localparam int unsigned ADDR_W   = 30;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MASK_W   = 4;
  localparam int unsigned MMIO_BIT = 29;

  // Read data returned when an MMIO access is abandoned by the watchdog.
  localparam logic [DATA_W-1:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mmio_req_t;

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port, synchronous-read, byte-enable data RAM.
// Ports:
//   clk, rst      clock, synchronous active-high reset (read register only)
//   we, re        write / read strobe for this cycle
//   addr          word index
//   wdata, wmask  write data and per-byte enables
//   rdata         read word, updated only on the edge ending a read cycle
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic                         re,
  input  logic [$clog2(RAM_WORDS)-1:0] addr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [MASK_W-1:0]            wmask,
  output logic [DATA_W-1:0]            rdata
);

  logic [DATA_W-1:0] mem [RAM_WORDS];

  // Byte-masked write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(MASK_W); b++) begin
        if (wmask[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register holds between reads so the load result stays stable.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: LSU-side data memory controller. Word addresses with bit 29
// clear hit the on-chip RAM (never stall, one-cycle load latency); bit 29
// set goes out over a valid/ready MMIO port while o_stall holds the core.
// Optional feature macro: DMEM_TIMEOUT_EN adds an MMIO watchdog, the
// TIMEOUT_CYCLES parameter and the o_bus_err output.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_req, i_is_store, i_addr,
//   i_store_data, i_store_mask   LSU access
//   o_load_data                  load result, cycle after acceptance
//   o_stall                      core must hold its request
//   o_mmio_*                     MMIO request channel
//   i_mmio_ready                 MMIO request accepted
//   i_mmio_rvalid, i_mmio_rdata  MMIO read response
//   o_bus_err                    (DMEM_TIMEOUT_EN) watchdog fired, one cycle
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS      = 1024
`ifdef DMEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_is_store,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic [MASK_W-1:0] i_store_mask,
  output logic [DATA_W-1:0] o_load_data,
  output logic              o_stall,
  output logic              o_mmio_valid,
  output logic              o_mmio_we,
  output logic [ADDR_W-1:0] o_mmio_addr,
  output logic [DATA_W-1:0] o_mmio_wdata,
  output logic [MASK_W-1:0] o_mmio_wmask,
  input  logic              i_mmio_ready,
  input  logic              i_mmio_rvalid,
  input  logic [DATA_W-1:0] i_mmio_rdata
`ifdef DMEM_TIMEOUT_EN
  , output logic            o_bus_err
`endif
);

  localparam int unsigned IDX_W = $clog2(RAM_WORDS);

  state_t            state_q, state_d;
  mmio_req_t         mmio_req_c;
  logic              is_mmio_c, accept_c, timeout_c;
  logic [DATA_W-1:0] ram_rdata, mmio_rdata_q, ld_mmio_q;
  logic              sel_mmio_q;

  assign is_mmio_c = i_addr[MMIO_BIT];
  assign accept_c  = i_req && !o_stall;

  // RAM path: only accepted, non-MMIO accesses touch the array.
  dmem_ram #(.RAM_WORDS(RAM_WORDS)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (accept_c && !is_mmio_c && i_is_store),
    .re    (accept_c && !is_mmio_c && !i_is_store),
    .addr  (i_addr[IDX_W-1:0]),
    .wdata (i_store_data),
    .wmask (i_store_mask),
    .rdata (ram_rdata)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Watchdog counts REQ/RESP cycles; it is zero whenever a new request starts.
  always_ff @(posedge clk) begin
    if (rst)                                           cnt_q <= '0;
    else if (state_q == ST_REQ || state_q == ST_RESP)  cnt_q <= cnt_q + CNT_W'(1);
    else                                               cnt_q <= '0;
  end

  // A ready/rvalid arriving on the last allowed cycle still wins.
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                     ((state_q == ST_REQ  && !i_mmio_ready) ||
                      (state_q == ST_RESP && !i_mmio_rvalid));

  // Set on the timeout edge, so it is high exactly for the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= timeout_c;
  end
  assign o_bus_err = err_q;
`else
  assign timeout_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_req && is_mmio_c) state_d = ST_REQ;
      ST_REQ: begin
        if (i_mmio_ready)   state_d = i_is_store ? ST_DONE : ST_RESP;
        else if (timeout_c) state_d = ST_DONE;
      end
      ST_RESP: if (i_mmio_rvalid || timeout_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: MMIO fields come straight from the held LSU request.
  always_comb begin
    o_stall      = 1'b0;
    o_mmio_valid = 1'b0;
    mmio_req_c   = '{we: i_is_store, addr: i_addr, wdata: i_store_data, wmask: i_store_mask};
    case (state_q)
      ST_IDLE: o_stall = i_req && is_mmio_c;
      ST_REQ: begin
        o_stall      = 1'b1;
        o_mmio_valid = 1'b1;
      end
      ST_RESP: o_stall = 1'b1;
      default: ;
    endcase
  end

  assign o_mmio_we    = mmio_req_c.we;
  assign o_mmio_addr  = mmio_req_c.addr;
  assign o_mmio_wdata = mmio_req_c.wdata;
  assign o_mmio_wmask = mmio_req_c.wmask;

  // MMIO response latch; rvalid outside RESP is ignored.
  always_ff @(posedge clk) begin
    if (rst)                                      mmio_rdata_q <= '0;
    else if (state_q == ST_RESP && i_mmio_rvalid) mmio_rdata_q <= i_mmio_rdata;
    else if (timeout_c)                           mmio_rdata_q <= BUS_ERR_DATA;
  end

  // Load result source; the MMIO copy is taken only when the held load is
  // accepted in DONE, so o_load_data stays put while a transaction runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_mmio_q <= 1'b0;
      ld_mmio_q  <= '0;
    end else if (accept_c && !i_is_store) begin
      sel_mmio_q <= is_mmio_c;
      if (is_mmio_c) ld_mmio_q <= mmio_rdata_q;
    end
  end

  assign o_load_data = sel_mmio_q ? ld_mmio_q : ram_rdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl (RAM merge,
// aliasing, masks, MMIO load/store handshakes, reset mid-transaction and,
// with DMEM_TIMEOUT_EN, the watchdog).
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, i_is_store = 1'b0;
  logic [29:0] i_addr = '0;
  logic [31:0] i_store_data = '0;
  logic [3:0]  i_store_mask = '0;
  logic [31:0] o_load_data;
  logic        o_stall, o_mmio_valid, o_mmio_we;
  logic [29:0] o_mmio_addr;
  logic [31:0] o_mmio_wdata;
  logic [3:0]  o_mmio_wmask;
  logic        i_mmio_ready = 1'b0, i_mmio_rvalid = 1'b0;
  logic [31:0] i_mmio_rdata = '0;
`ifdef DMEM_TIMEOUT_EN
  logic        o_bus_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .RAM_WORDS(1024)
`ifdef DMEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_is_store(i_is_store), .i_addr(i_addr),
    .i_store_data(i_store_data), .i_store_mask(i_store_mask),
    .o_load_data(o_load_data), .o_stall(o_stall),
    .o_mmio_valid(o_mmio_valid), .o_mmio_we(o_mmio_we), .o_mmio_addr(o_mmio_addr),
    .o_mmio_wdata(o_mmio_wdata), .o_mmio_wmask(o_mmio_wmask),
    .i_mmio_ready(i_mmio_ready), .i_mmio_rvalid(i_mmio_rvalid), .i_mmio_rdata(i_mmio_rdata)
`ifdef DMEM_TIMEOUT_EN
    , .o_bus_err(o_bus_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic st, input logic [29:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    i_req = req; i_is_store = st; i_addr = a; i_store_data = d; i_store_mask = m;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
  endtask

  int stalls, valids;

  initial begin
    // Reset
    tick(); tick();
    rst = 1'b0;
    #2;
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_valid", 32'(o_mmio_valid), 32'd0);
    check("rst_load",  o_load_data, 32'h0);

    // Byte-merge store then load
    drive(1'b1, 1'b1, 30'h10, 32'h1122_3344, 4'hF); #2;
    check("ram_no_stall", 32'(o_stall), 32'd0);
    tick();
    drive(1'b1, 1'b1, 30'h10, 32'hAA00_0000, 4'h8); tick();
    drive(1'b1, 1'b0, 30'h10, 32'h0, 4'h0); tick();
    idle(); #2;
    check("ram_merge", o_load_data, 32'hAA22_3344);
    tick(); #2;
    check("ram_hold", o_load_data, 32'hAA22_3344);

    // Aliasing: 0x410 and 0x010 share a RAM word
    drive(1'b1, 1'b1, 30'h410, 32'h5A5A_1234, 4'hF); tick();
    drive(1'b1, 1'b0, 30'h010, 32'h0, 4'h0); tick();
    idle(); #2;
    check("ram_alias", o_load_data, 32'h5A5A_1234);

    // Mask 0 and i_req=0 must not write
    drive(1'b1, 1'b1, 30'h20, 32'h1234_5678, 4'hF); tick();
    drive(1'b1, 1'b1, 30'h20, 32'hFFFF_FFFF, 4'h0); tick();
    drive(1'b0, 1'b1, 30'h20, 32'hEEEE_EEEE, 4'hF); tick();
    drive(1'b1, 1'b0, 30'h20, 32'h0, 4'h0); tick();
    idle(); #2;
    check("ram_mask0_noreq", o_load_data, 32'h1234_5678);
    tick();

    // MMIO load: ready on 3rd REQ cycle, rvalid 2 cycles later
    stalls = 0;
    drive(1'b1, 1'b0, 30'h2000_0004, 32'h0, 4'h0);
    for (int k = 0; k < 20; k++) begin
      i_mmio_ready  = (k == 3);
      i_mmio_rvalid = (k == 5);
      i_mmio_rdata  = (k == 5) ? 32'hCAFE_F00D : 32'h0;
      #2;
      if (k == 0) check("mmio_ld_valid_idle", 32'(o_mmio_valid), 32'd0);
      if (k == 1) begin
        check("mmio_ld_valid", 32'(o_mmio_valid), 32'd1);
        check("mmio_ld_we", 32'(o_mmio_we), 32'd0);
        check("mmio_ld_addr", 32'(o_mmio_addr), 32'h2000_0004);
      end
      if (k == 4) check("mmio_ld_valid_resp", 32'(o_mmio_valid), 32'd0);
      if (!o_stall) begin
        check("mmio_ld_hold_done", o_load_data, 32'h1234_5678);
        break;
      end
      stalls++;
      tick();
    end
    check("mmio_ld_stalls", 32'(stalls), 32'd6);
    i_mmio_ready = 1'b0; i_mmio_rvalid = 1'b0; i_mmio_rdata = 32'h0;
    tick();
    idle(); #2;
    check("mmio_ld_data", o_load_data, 32'hCAFE_F00D);
    tick();

    // MMIO store with ready present as soon as valid rises
    stalls = 0; valids = 0;
    drive(1'b1, 1'b1, 30'h2000_0010, 32'h0BAD_CAFE, 4'b0101);
    i_mmio_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #2;
      if (o_mmio_valid) begin
        valids++;
        check("mmio_st_we", 32'(o_mmio_we), 32'd1);
        check("mmio_st_addr", 32'(o_mmio_addr), 32'h2000_0010);
        check("mmio_st_wdata", o_mmio_wdata, 32'h0BAD_CAFE);
        check("mmio_st_wmask", 32'(o_mmio_wmask), 32'h5);
      end
      if (!o_stall) break;
      stalls++;
      tick();
    end
    check("mmio_st_stalls", 32'(stalls), 32'd2);
    check("mmio_st_valids", 32'(valids), 32'd1);
    i_mmio_ready = 1'b0;
    tick();
    idle(); #2;
    check("mmio_st_keeps_load", o_load_data, 32'hCAFE_F00D);
    tick();

    // Reset while waiting in RESP, then a late rvalid
    drive(1'b1, 1'b0, 30'h2000_0008, 32'h0, 4'h0); #2;
    tick();
    i_mmio_ready = 1'b1; #2;
    check("rst_mid_valid", 32'(o_mmio_valid), 32'd1);
    tick();
    i_mmio_ready = 1'b0; #2;
    check("rst_mid_resp_stall", 32'(o_stall), 32'd1);
    rst = 1'b1; idle();
    tick();
    rst = 1'b0;
    i_mmio_rvalid = 1'b1; i_mmio_rdata = 32'h1212_1212; #2;
    check("rst_mid_stall", 32'(o_stall), 32'd0);
    check("rst_mid_valid_lo", 32'(o_mmio_valid), 32'd0);
    check("rst_mid_load", o_load_data, 32'h0);
    tick();
    i_mmio_rvalid = 1'b0; i_mmio_rdata = 32'h0; #2;
    check("rst_mid_late_rvalid", o_load_data, 32'h0);
    check("rst_mid_idle_stall", 32'(o_stall), 32'd0);
    tick();

`ifdef DMEM_TIMEOUT_EN
    // Watchdog: ready never arrives, 1 IDLE + 8 REQ stall cycles
    stalls = 0;
    drive(1'b1, 1'b0, 30'h2000_000C, 32'h0, 4'h0);
    for (int k = 0; k < 40; k++) begin
      #2;
      if (!o_stall) break;
      check("to_no_err_early", 32'(o_bus_err), 32'd0);
      stalls++;
      tick();
    end
    check("to_stalls", 32'(stalls), 32'd9);
    check("to_bus_err", 32'(o_bus_err), 32'd1);
    tick();
    idle(); #2;
    check("to_data", o_load_data, 32'hDEAD_BEEF);
    check("to_err_pulse", 32'(o_bus_err), 32'd0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
